// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and helpers shared by the ALU command sequencer
package alu_seq_pkg;

    localparam logic [3:0] OP_NOT         = 4'd0;
    localparam logic [3:0] OP_AND         = 4'd1;
    localparam logic [3:0] OP_XOR         = 4'd2;
    localparam logic [3:0] OP_OR          = 4'd3;
    localparam logic [3:0] OP_DEC         = 4'd4;
    localparam logic [3:0] OP_ADD         = 4'd5;
    localparam logic [3:0] OP_SUB         = 4'd6;
    localparam logic [3:0] OP_INC         = 4'd7;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op < OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - NREG x DATA_W register file, two combinational reads, one write
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter int RA_W   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - ALU command master: operand fetch, execute, writeback, response; ALU_SEQ_STATS_EN adds counters
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [RA_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic [RA_W-1:0]   cmd_rs,
    input  logic [RA_W-1:0]   cmd_rt,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_is0,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
`ifdef ALU_SEQ_STATS_EN
   ,output logic [15:0]       stat_cmds,
    output logic [15:0]       stat_zero
`endif
);

    seq_state_t        state;
    logic [RA_W-1:0]   rd_q;
    logic              accept;
    logic              legal;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    assign cmd_ready = (state == IDLE) && !ld_en;
    assign accept    = cmd_valid && cmd_ready;
    assign legal     = op_is_legal(alu_op);

    // Preload owns the write port in IDLE; writeback owns it in EXEC, so they never collide.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
        if (state == IDLE && ld_en) begin
            rf_we = 1'b1;
        end else if (state == EXEC && legal) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = alu_result;
        end
    end

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (cmd_rs),
        .rdata_a (rf_rdata_a),
        .raddr_b (cmd_rt),
        .rdata_b (rf_rdata_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_q      <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_op <= cmd_op;
                        alu_a  <= rf_rdata_a;
                        alu_b  <= rf_rdata_b;
                        rd_q   <= cmd_rd;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= !legal;
                    rsp_data  <= legal ? alu_result : '0;
                    rsp_zero  <= legal && alu_is0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cmds <= '0;
            stat_zero <= '0;
        end else if (state == EXEC) begin
            if (stat_cmds != 16'hFFFF) begin
                stat_cmds <= stat_cmds + 16'd1;
            end
            if (legal && alu_is0 && stat_zero != 16'hFFFF) begin
                stat_zero <= stat_zero + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a behavioural ALU alongside
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int RW = 3;

    logic          clk;
    logic          rst_n;
    logic          ld_en;
    logic [RW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [RW-1:0] cmd_rd, cmd_rs, cmd_rt;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          alu_is0;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero, rsp_err;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]   stat_cmds, stat_zero;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mregs [NR];
    int            mcmds  = 0;
    int            mzeros = 0;

    alu_cmd_sequencer #(.DATA_W(DW), .NREG(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_is0    (alu_is0),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
`ifdef ALU_SEQ_STATS_EN
       ,.stat_cmds  (stat_cmds),
        .stat_zero  (stat_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external combinational 32-bit ALU.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_NOT:  alu_result = alu_a ^ {DW{1'b1}};
            OP_AND:  alu_result = alu_a & alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_DEC:  alu_result = alu_a + {DW{1'b1}};
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a + ~alu_b + 1'b1;
            OP_INC:  alu_result = alu_a + 1'b1;
            default: alu_result = '0;
        endcase
        alu_is0 = (alu_result == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_exec(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     output logic [DW-1:0] d, output logic z, output logic e);
        longint unsigned la, lb, r;
        la = a;
        lb = b;
        case (op)
            4'd0:    r = (64'h1_0000_0000 - 1) - la;
            4'd1:    r = la & lb;
            4'd2:    r = la ^ lb;
            4'd3:    r = la | lb;
            4'd4:    r = (la + 64'h1_0000_0000 - 1) % 64'h1_0000_0000;
            4'd5:    r = (la + lb) % 64'h1_0000_0000;
            4'd6:    r = (la + 64'h1_0000_0000 - lb) % 64'h1_0000_0000;
            4'd7:    r = (la + 1) % 64'h1_0000_0000;
            default: r = 0;
        endcase
        e = (op >= 4'd8);
        d = e ? '0 : r[DW-1:0];
        z = !e && (r == 0);
    endfunction

    task automatic preload(input logic [RW-1:0] addr, input logic [DW-1:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
        mregs[addr] = data;
    endtask

    // Issues one command at posedge+1, holds rsp_ready low for `hold` cycles, then completes the handshake.
    task automatic run_cmd(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                           input logic [RW-1:0] rt, input int hold,
                           output logic [DW-1:0] got_d, output logic got_z, output logic got_e);
        logic [DW-1:0] ed;
        logic          ez, ee;
        ref_exec(op, mregs[rs], mregs[rt], ed, ez, ee);
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_valid = 1'b1;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("rsp_valid_exec", rsp_valid, 0);
        @(posedge clk); #1;
        check("rsp_valid_rise", rsp_valid, 1);
        check("rsp_data", rsp_data, ed);
        check("rsp_zero", rsp_zero, ez);
        check("rsp_err", rsp_err, ee);
        got_d = rsp_data;
        got_z = rsp_zero;
        got_e = rsp_err;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, ed);
            check("hold_err", rsp_err, ee);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        if (!ee) mregs[rd] = ed;
        mcmds++;
        if (!ee && ez) mzeros++;
    endtask

    typedef struct {
        logic [3:0]    op;
        logic [RW-1:0] rd, rs, rt;
        logic [DW-1:0] data;
        logic          zero;
        logic          err;
    } vec_t;

    vec_t vt [10];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] gd;
        logic          gz, ge;
        logic [3:0]    rop;

        vt[0] = '{OP_ADD, 3'd3, 3'd1, 3'd2, 32'd8,          1'b0, 1'b0};
        vt[1] = '{OP_SUB, 3'd4, 3'd1, 3'd1, 32'd0,          1'b1, 1'b0};
        vt[2] = '{OP_DEC, 3'd5, 3'd0, 3'd0, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vt[3] = '{4'd8,   3'd3, 3'd1, 3'd2, 32'd0,          1'b0, 1'b1};
        vt[4] = '{OP_OR,  3'd6, 3'd3, 3'd3, 32'd8,          1'b0, 1'b0};
        vt[5] = '{OP_INC, 3'd7, 3'd5, 3'd5, 32'd0,          1'b1, 1'b0};
        vt[6] = '{OP_NOT, 3'd0, 3'd4, 3'd4, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vt[7] = '{OP_XOR, 3'd1, 3'd0, 3'd2, 32'hFFFF_FFFC,  1'b0, 1'b0};
        vt[8] = '{OP_AND, 3'd2, 3'd1, 3'd6, 32'd8,          1'b0, 1'b0};
        vt[9] = '{4'd15,  3'd0, 3'd0, 3'd0, 32'd0,          1'b0, 1'b1};

        for (int i = 0; i < NR; i++) mregs[i] = '0;
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_zero", rsp_zero, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_alu_op", alu_op, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_cmd_ready", cmd_ready, 1);
`ifdef ALU_SEQ_STATS_EN
        check("reset_stat_cmds", stat_cmds, 0);
        check("reset_stat_zero", stat_zero, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        preload(3'd1, 32'd5);
        preload(3'd2, 32'd3);
        for (int i = 0; i < 10; i++) begin
            run_cmd(vt[i].op, vt[i].rd, vt[i].rs, vt[i].rt, 0, gd, gz, ge);
            check($sformatf("vec%0d_data", i), gd, vt[i].data);
            check($sformatf("vec%0d_zero", i), gz, vt[i].zero);
            check($sformatf("vec%0d_err", i), ge, vt[i].err);
        end

        // Response backpressure: r2=8, r6=8.
        run_cmd(OP_ADD, 3'd3, 3'd2, 3'd6, 5, gd, gz, ge);
        check("hold_sum", gd, 32'd16);

        // Preload wins over a simultaneous command.
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 32'hA5A5_0001;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd5; cmd_rs = 3'd1; cmd_rt = 3'd1;
        #1;
        check("ld_blocks_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        ld_en = 1'b0; cmd_valid = 1'b0;
        mregs[4] = 32'hA5A5_0001;
        check("ld_no_accept", rsp_valid, 0);
        #1;
        check("ld_idle_again", cmd_ready, 1);
        run_cmd(OP_OR, 3'd5, 3'd4, 3'd4, 0, gd, gz, ge);
        check("ld_written", gd, 32'hA5A5_0001);

        // Preload during EXEC is ignored.
        cmd_valid = 1'b1; cmd_op = OP_INC; cmd_rd = 3'd6; cmd_rs = 3'd6; cmd_rt = 3'd6;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ld_en = 1'b0;
        check("exec_ld_rsp_valid", rsp_valid, 1);
        check("exec_ld_rsp_data", rsp_data, mregs[6] + 32'd1);
        mregs[6] = mregs[6] + 32'd1;
        mcmds++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run_cmd(OP_OR, 3'd7, 3'd2, 3'd2, 0, gd, gz, ge);
        check("exec_ld_ignored", gd, 32'd8);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0:       preload(3'($urandom_range(0, 7)), 32'd0);
                    1:       preload(3'($urandom_range(0, 7)), 32'hFFFF_FFFF);
                    default: preload(3'($urandom_range(0, 7)), $urandom);
                endcase
            end
            rop = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            run_cmd(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 2), gd, gz, ge);
        end

`ifdef ALU_SEQ_STATS_EN
        check("stat_cmds", stat_cmds, 64'(mcmds));
        check("stat_zero", stat_zero, 64'(mzeros));
`endif

        // Reset while a command is in EXEC.
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd7; cmd_rs = 3'd1; cmd_rt = 3'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_exec_rsp_valid", rsp_valid, 0);
        check("rst_exec_alu_op", alu_op, 0);
        check("rst_exec_alu_a", alu_a, 0);
        check("rst_exec_rsp_data", rsp_data, 0);
`ifdef ALU_SEQ_STATS_EN
        check("rst_exec_stat_cmds", stat_cmds, 0);
        check("rst_exec_stat_zero", stat_zero, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mcmds = 0;
        mzeros = 0;
        @(posedge clk); #1;
        for (int i = 1; i < NR; i++) begin
            run_cmd(OP_OR, 3'd0, 3'(i), 3'(i), 0, gd, gz, ge);
            check($sformatf("post_rst_r%0d", i), gd, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
